// File: rtl/ps2_kb_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kb_receiver
//  Description : PS/2 keyboard frame receiver. Synchronizes and de-glitches
//                the keyboard clock, deserializes 11-bit frames (start, 8
//                data LSB first, odd parity, stop), checks parity/framing,
//                abandons stalled frames after a timeout, and delivers scan
//                codes as a one-cycle strobe.
//
//  Parameters  : FILTER_LEN - cycles the synced PS2_CLK must hold a new level
//                             before the filtered clock follows it
//                TIMEOUT    - idle cycles mid-frame before the frame is dropped
//
//  Ports       : CLK      in   system clock (25 MHz)
//                ARST_L   in   synchronous active-low reset
//                PS2_CLK  in   keyboard clock pin (asynchronous, idles high)
//                PS2_DATA in   keyboard data pin (asynchronous, idles high)
//                KBCODE   out  last delivered scan code, held between strobes
//                KBSTROBE out  one-cycle pulse, KBCODE valid in that cycle
//                KBEXT    out  code was preceded by E0 (qualifies KBSTROBE)
//                KBERR    out  one-cycle pulse on parity/framing/timeout error
//
//  Build macro : PS2_BREAK_FILTER_EN - when defined, E0/F0 prefixes are
//                consumed, release codes are suppressed and KBEXT is driven.
//                When undefined every valid byte is strobed and KBEXT is 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kb_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] KBCODE,
  output logic       KBSTROBE,
  output logic       KBEXT,
  output logic       KBERR
);

  localparam int          FW      = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [14:0] TO_VAL  = 15'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          ps2c_f, ps2c_f_d;
  logic          fall;

  always_ff @(posedge CLK) begin
    if (!ARST_L) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_cnt <= '0;
      ps2c_f   <= 1'b1;
      ps2c_f_d <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      dat_s1   <= PS2_DATA;
      dat_s2   <= dat_s1;
      ps2c_f_d <= ps2c_f;
      // Count consecutive cycles the synced clock disagrees with the filtered
      // one; any return to agreement restarts the count, so short glitches die.
      if (clk_s2 == ps2c_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_cnt <= '0;
        ps2c_f   <= clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Fall event: the cycle in which the filtered clock has just dropped.
  assign fall = ps2c_f_d & ~ps2c_f;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  logic [1:0]  state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic [14:0] idle_cnt;
  logic        timeout;

  // A fall in the same cycle takes priority over the timeout.
  assign timeout = (state != S_IDLE) && !fall && (idle_cnt == TO_VAL);

  always_ff @(posedge CLK) begin
    if (!ARST_L) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall && !dat_s2)              state_nxt = S_DATA;
      S_DATA:   if (fall && (bit_cnt == 3'd7))    state_nxt = S_PARITY;
      S_PARITY: if (fall)                         state_nxt = S_STOP;
      S_STOP:   if (fall)                         state_nxt = S_IDLE;
      default:                                    state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  logic byte_done, frame_ok, is_e0, is_f0;
  logic strobe_nxt, err_nxt;

`ifdef PS2_BREAK_FILTER_EN
  logic ext_flag, brk_flag, kbext_r;
`endif

  always_comb begin
    byte_done = (state == S_STOP) && fall;
    // Odd parity over data+parity, and the stop bit sampled in this fall.
    frame_ok  = ((^shift) ^ par_bit) & dat_s2;
    is_e0     = (shift == 8'hE0);
    is_f0     = (shift == 8'hF0);
    err_nxt   = (byte_done && !frame_ok) || timeout;
`ifdef PS2_BREAK_FILTER_EN
    strobe_nxt = byte_done && frame_ok && !is_e0 && !is_f0 && !brk_flag;
`else
    strobe_nxt = byte_done && frame_ok;
`endif
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!ARST_L) begin
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      idle_cnt <= '0;
      KBCODE   <= 8'h00;
      KBSTROBE <= 1'b0;
      KBERR    <= 1'b0;
    end else begin
      if (fall || (state == S_IDLE)) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + 15'd1;

      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_s2;
          default: ;
        endcase
      end

      KBSTROBE <= strobe_nxt;
      KBERR    <= err_nxt;
      if (strobe_nxt) KBCODE <= shift;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  // Prefix tracking: E0 marks the next code as extended, F0 marks it as a
  // release which is swallowed. Any completed non-prefix byte or bad frame
  // clears both flags.
  always_ff @(posedge CLK) begin
    if (!ARST_L) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      kbext_r  <= 1'b0;
    end else begin
      if (byte_done) begin
        if (!frame_ok) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else if (is_e0) begin
          ext_flag <= 1'b1;
        end else if (is_f0) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
      if (strobe_nxt) kbext_r <= ext_flag;
    end
  end

  assign KBEXT = kbext_r;
`else
  assign KBEXT = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_kb_receiver
//  Description : Self-checking bench for ps2_kb_receiver. A keyboard model
//                drives PS/2 frames; expected deliveries/errors are queued as
//                frames are sent and popped when the DUT pulses an output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kb_receiver;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;   // PS/2 half-period in system clock cycles

  logic       clk = 1'b0;
  logic       arst_l = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kbcode;
  logic       kbstrobe, kbext, kberr;

  ps2_kb_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK      (clk),
    .ARST_L   (arst_l),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .KBCODE   (kbcode),
    .KBSTROBE (kbstrobe),
    .KBEXT    (kbext),
    .KBERR    (kberr)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       err;
    logic       lat;   // latency from stop-bit pin fall is checked
  } ev_t;

  ev_t        sb[$];
  ev_t        ev;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         stop_cyc = 0;
  logic [7:0] last_code = 8'h00;
  bit         ext_m = 1'b0;
  bit         brk_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (arst_l) begin
      if (kbstrobe && kberr) begin
        chk("strobe_and_err", 32'd1, 32'd0);
      end else if (kbstrobe || kberr) begin
        if (sb.size() == 0) begin
          chk(kbstrobe ? "unexpected_strobe" : "unexpected_err", 32'd1, 32'd0);
        end else begin
          ev = sb.pop_front();
          chk("event_kind_err", 32'(kberr), 32'(ev.err));
          if (kbstrobe) begin
            chk("kbcode", 32'(kbcode), 32'(ev.code));
            chk("kbext", 32'(kbext), 32'(ev.ext));
          end
          if (ev.lat) chk("latency", 32'(cyc - stop_cyc), 32'(FL + 3));
        end
      end
    end
  end

  task automatic push(input logic [7:0] c, input logic e, input logic er, input logic l);
    ev_t x;
    x.code = c; x.ext = e; x.err = er; x.lat = l;
    sb.push_back(x);
  endtask

  // Reference behaviour for one completed frame.
  task automatic model(input logic [7:0] b, input bit ok);
    if (!ok) begin
      push(8'h00, 1'b0, 1'b1, 1'b1);
      ext_m = 1'b0;
      brk_m = 1'b0;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (b == 8'hE0) ext_m = 1'b1;
      else if (b == 8'hF0) brk_m = 1'b1;
      else if (brk_m) begin
        brk_m = 1'b0;
        ext_m = 1'b0;
      end else begin
        push(b, ext_m, 1'b0, 1'b1);
        last_code = b;
        ext_m = 1'b0;
      end
`else
      push(b, 1'b0, 1'b0, 1'b1);
      last_code = b;
`endif
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    model(b, !bad_par && !bad_stop);
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (FL + 10) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_kbcode"}, 32'(kbcode), 32'h00);
    chk({tag, "_kbstrobe"}, 32'(kbstrobe), 32'd0);
    chk({tag, "_kbext"}, 32'(kbext), 32'd0);
    chk({tag, "_kberr"}, 32'(kberr), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    arst_l = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    arst_l = 1'b1;
    repeat (5) @(negedge clk);

    // Valid frame
    send_frame(8'h1D, 1'b0, 1'b0);
    chk("code_after_1d", 32'(kbcode), 32'h1D);

    // Release filtering
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    chk("code_after_release", 32'(kbcode), 32'(last_code));
    send_frame(8'h23, 1'b0, 1'b0);
    chk("code_after_23", 32'(kbcode), 32'h23);

    // Extended key
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("code_after_ext", 32'(kbcode), 32'h75);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Parity and stop errors leave KBCODE untouched
    send_frame(8'h23, 1'b1, 1'b0);
    chk("code_after_par_err", 32'(kbcode), 32'h1C);
    send_frame(8'h23, 1'b0, 1'b1);
    chk("code_after_stop_err", 32'(kbcode), 32'h1C);

    // Timeout after start + 5 data bits, then recovery
    push(8'h00, 1'b0, 1'b1, 1'b0);
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 6);
    repeat (TO + 60) @(negedge clk);
    chk("timeout_drained", 32'(sb.size()), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("code_after_timeout", 32'(kbcode), 32'h1C);

    // Short low glitch with data low must not start a frame
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk  = 1'b1;
    repeat (30) @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h2B, 1'b0, 1'b0);
    chk("code_after_glitch", 32'(kbcode), 32'h2B);

    // Reset mid-frame (pin clock high at that moment)
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 4);
    @(negedge clk);
    arst_l = 1'b0;
    @(negedge clk);
    arst_l = 1'b1;
    chk_reset_outputs("midreset");
    last_code = 8'h00;
    ext_m = 1'b0;
    brk_m = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h1B, 1'b0, 1'b0);
    chk("code_after_reset", 32'(kbcode), 32'h1B);

    repeat (50) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
